// File: rtl/scpu_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// scpu_mem_arbiter_pkg
// Shared definitions for the SCPU SRAM arbiter: default widths, requester
// port indices and FSM state encodings.
// Optional build macro used by the arbiter: SCPU_ARB_RR_EN.
// -----------------------------------------------------------------------------
package scpu_mem_arbiter_pkg;

   localparam int unsigned ARB_AW           = 9;
   localparam int unsigned ARB_DW           = 8;
   localparam int unsigned ARB_LOCK_TIMEOUT = 4;

   // Requester indices into the one-hot grant vector
   localparam int unsigned ARB_NPORT = 3;
   localparam int unsigned ARB_H     = 0;
   localparam int unsigned ARB_D     = 1;
   localparam int unsigned ARB_I     = 2;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_LOCK_D = 2'd1,
      ARB_LOCK_I = 2'd2
   } arb_state_e;

   function automatic logic arb_is_locked(input arb_state_e s);
      return (s == ARB_LOCK_D) || (s == ARB_LOCK_I);
   endfunction

endpackage

// File: rtl/scpu_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// scpu_mem_arbiter_if
// Bundles the three requester handshakes (host H, CPU data D, CPU instruction
// I), the shared read-return bus, cpu_hold and the SRAM macro port.
//   slave  : arbiter view (requests/SRAM read data in, grants/SRAM controls out)
//   master : requester/SRAM-model view (the opposite directions)
// -----------------------------------------------------------------------------
interface scpu_mem_arbiter_if
   import scpu_mem_arbiter_pkg::*;
#(
   parameter int unsigned AW = ARB_AW,
   parameter int unsigned DW = ARB_DW
) ();

   logic          h_req,    d_req,    i_req;
   logic [AW-1:0] h_addr,   d_addr,   i_addr;
   logic          h_we,     d_we;
   logic [DW-1:0] h_wdata,  d_wdata;
   logic          d_lock,   i_lock;
   logic          h_gnt,    d_gnt,    i_gnt;
   logic          h_rvalid, d_rvalid, i_rvalid;
   logic [DW-1:0] rdata;
   logic          cpu_hold;

   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   modport slave (
      input  h_req, d_req, i_req, h_addr, d_addr, i_addr,
      input  h_we, d_we, h_wdata, d_wdata, d_lock, i_lock,
      output h_gnt, d_gnt, i_gnt, h_rvalid, d_rvalid, i_rvalid,
      output rdata, cpu_hold,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output h_req, d_req, i_req, h_addr, d_addr, i_addr,
      output h_we, d_we, h_wdata, d_wdata, d_lock, i_lock,
      input  h_gnt, d_gnt, i_gnt, h_rvalid, d_rvalid, i_rvalid,
      input  rdata, cpu_hold,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );

endinterface

// File: rtl/scpu_mem_arbiter_pick.sv
// -----------------------------------------------------------------------------
// scpu_mem_arbiter_pick
// Combinational winner select: {requests, FSM state, rr pointer} -> one-hot
// grant. A locked owner excludes everyone else; in IDLE the host always wins,
// then D over I (fixed) or round-robin between D and I (SCPU_ARB_RR_EN).
// Ports:
//   i_h_req/i_d_req/i_i_req  beat requests
//   i_state                  arbiter FSM state
//   i_rr_last_i              (SCPU_ARB_RR_EN only) 1 = I served last
//   o_gnt_c                  one-hot grant {I, D, H}
// -----------------------------------------------------------------------------
module scpu_mem_arbiter_pick
   import scpu_mem_arbiter_pkg::*;
(
   input  logic                 i_h_req,
   input  logic                 i_d_req,
   input  logic                 i_i_req,
   input  arb_state_e           i_state,
`ifdef SCPU_ARB_RR_EN
   input  logic                 i_rr_last_i,
`endif
   output logic [ARB_NPORT-1:0] o_gnt_c
);

   logic w_d_first;

   // D wins a D/I tie unless round-robin says D was served last
`ifdef SCPU_ARB_RR_EN
   assign w_d_first = i_rr_last_i;
`else
   assign w_d_first = 1'b1;
`endif

   always_comb begin
      o_gnt_c = '0;
      case (i_state)
         ARB_LOCK_D: o_gnt_c[ARB_D] = i_d_req;
         ARB_LOCK_I: o_gnt_c[ARB_I] = i_i_req;
         default: begin
            if (i_h_req)                          o_gnt_c[ARB_H] = 1'b1;
            else if (i_d_req && (!i_i_req || w_d_first)) o_gnt_c[ARB_D] = 1'b1;
            else if (i_i_req)                     o_gnt_c[ARB_I] = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/scpu_mem_arbiter.sv
// -----------------------------------------------------------------------------
// scpu_mem_arbiter
// Shares one single-port byte-wide SRAM between host loader (H), CPU data (D)
// and CPU instruction (I) ports. CPU words move as two byte beats kept atomic
// by a lock; an idle locked owner is force-released after LOCK_TIMEOUT cycles.
// Optional build macro: SCPU_ARB_RR_EN (round-robin between D and I in IDLE).
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   scpu_mem_arbiter_if.slave: requester handshakes (gnt combinational,
//         rvalid one cycle after a granted read), shared rdata, registered
//         cpu_hold, SRAM controls (driven in the grant cycle)
// -----------------------------------------------------------------------------
module scpu_mem_arbiter
   import scpu_mem_arbiter_pkg::*;
#(
   parameter int unsigned AW           = ARB_AW,
   parameter int unsigned DW           = ARB_DW,
   parameter int unsigned LOCK_TIMEOUT = ARB_LOCK_TIMEOUT
) (
   input  logic                clk,
   input  logic                rst,
   scpu_mem_arbiter_if.slave   bus
);

   localparam int unsigned CNT_W = $clog2(LOCK_TIMEOUT + 1);

   arb_state_e           r_state;
   logic [CNT_W-1:0]     r_cnt;
   logic [ARB_NPORT-1:0] r_rd_pend;
   logic                 r_hold;
`ifdef SCPU_ARB_RR_EN
   logic                 r_rr_last_i;
`endif

   logic [ARB_NPORT-1:0] w_pick;
   logic [ARB_NPORT-1:0] w_gnt;
   logic                 w_mem_en;
   logic                 w_mem_we;
   logic [AW-1:0]        w_mem_addr;
   logic [DW-1:0]        w_mem_wdata;
   logic                 w_locked;
   logic                 w_own_gnt;
   logic                 w_own_lock;

   scpu_mem_arbiter_pick u_pick (
      .i_h_req     (bus.h_req),
      .i_d_req     (bus.d_req),
      .i_i_req     (bus.i_req),
      .i_state     (r_state),
`ifdef SCPU_ARB_RR_EN
      .i_rr_last_i (r_rr_last_i),
`endif
      .o_gnt_c     (w_pick)
   );

   // No grant is issued while reset is asserted
   assign w_gnt    = w_pick & {ARB_NPORT{~rst}};
   assign w_locked = arb_is_locked(r_state);

   // Route the winner's beat onto the SRAM port
   always_comb begin
      w_mem_en    = 1'b0;
      w_mem_we    = 1'b0;
      w_mem_addr  = '0;
      w_mem_wdata = '0;
      if (w_gnt[ARB_H]) begin
         w_mem_en    = 1'b1;
         w_mem_we    = bus.h_we;
         w_mem_addr  = bus.h_addr;
         w_mem_wdata = bus.h_wdata;
      end else if (w_gnt[ARB_D]) begin
         w_mem_en    = 1'b1;
         w_mem_we    = bus.d_we;
         w_mem_addr  = bus.d_addr;
         w_mem_wdata = bus.d_wdata;
      end else if (w_gnt[ARB_I]) begin
         w_mem_en    = 1'b1;
         w_mem_addr  = bus.i_addr;
      end
   end

   // Grant/lock of the current lock owner
   always_comb begin
      w_own_gnt  = 1'b0;
      w_own_lock = 1'b0;
      if (r_state == ARB_LOCK_D) begin
         w_own_gnt  = w_gnt[ARB_D];
         w_own_lock = bus.d_lock;
      end else if (r_state == ARB_LOCK_I) begin
         w_own_gnt  = w_gnt[ARB_I];
         w_own_lock = bus.i_lock;
      end
   end

   // FSM, lock counter, read-return pipe and cpu_hold
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ARB_IDLE;
         r_cnt       <= '0;
         r_rd_pend   <= '0;
         r_hold      <= 1'b0;
`ifdef SCPU_ARB_RR_EN
         r_rr_last_i <= 1'b1;
`endif
      end else begin
         r_hold    <= bus.h_req & ~w_locked;
         r_rd_pend <= w_gnt & {ARB_NPORT{~w_mem_we}};
`ifdef SCPU_ARB_RR_EN
         if (w_gnt[ARB_D])      r_rr_last_i <= 1'b0;
         else if (w_gnt[ARB_I]) r_rr_last_i <= 1'b1;
`endif
         case (r_state)
            ARB_IDLE: begin
               r_cnt <= '0;
               if (w_gnt[ARB_D] && bus.d_lock)      r_state <= ARB_LOCK_D;
               else if (w_gnt[ARB_I] && bus.i_lock) r_state <= ARB_LOCK_I;
            end
            ARB_LOCK_D, ARB_LOCK_I: begin
               if (w_own_gnt) begin
                  r_cnt <= '0;
                  if (!w_own_lock) r_state <= ARB_IDLE;
               end else if (r_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                  // Owner idle for LOCK_TIMEOUT cycles: force release
                  r_cnt   <= '0;
                  r_state <= ARB_IDLE;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: begin
               r_cnt   <= '0;
               r_state <= ARB_IDLE;
            end
         endcase
      end
   end

   assign bus.h_gnt     = w_gnt[ARB_H];
   assign bus.d_gnt     = w_gnt[ARB_D];
   assign bus.i_gnt     = w_gnt[ARB_I];
   // A read pending across a reset is squashed
   assign bus.h_rvalid  = r_rd_pend[ARB_H] & ~rst;
   assign bus.d_rvalid  = r_rd_pend[ARB_D] & ~rst;
   assign bus.i_rvalid  = r_rd_pend[ARB_I] & ~rst;
   assign bus.rdata     = bus.mem_rdata;
   assign bus.cpu_hold  = r_hold;
   assign bus.mem_en    = w_mem_en;
   assign bus.mem_we    = w_mem_we;
   assign bus.mem_addr  = w_mem_addr;
   assign bus.mem_wdata = w_mem_wdata;

endmodule

// File: tb/tb_scpu_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_scpu_mem_arbiter
// Directed bench for scpu_mem_arbiter with a behavioural 1-cycle-latency SRAM.
// Table of single-cycle arbitration vectors plus hand-written sequences for
// reset, locked pairs, contention, lock timeout and reset mid-read.
// Expectations follow SCPU_ARB_RR_EN where the D/I tie order differs.
// -----------------------------------------------------------------------------
module tb_scpu_mem_arbiter;

   localparam int unsigned AW = 9;
   localparam int unsigned DW = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   scpu_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   scpu_mem_arbiter #(.AW(AW), .DW(DW), .LOCK_TIMEOUT(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // SRAM model
   logic [DW-1:0] mem [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
         else            bus.mem_rdata     <= mem[bus.mem_addr];
      end
   end

   int n_run  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] gv();
      return 32'({bus.i_gnt, bus.d_gnt, bus.h_gnt});
   endfunction

   function automatic logic [31:0] rv();
      return 32'({bus.i_rvalid, bus.d_rvalid, bus.h_rvalid});
   endfunction

   task automatic clr_in();
      bus.h_req = 1'b0; bus.d_req = 1'b0; bus.i_req = 1'b0;
      bus.h_addr = '0;  bus.d_addr = '0;  bus.i_addr = '0;
      bus.h_we = 1'b0;  bus.d_we = 1'b0;
      bus.h_wdata = '0; bus.d_wdata = '0;
      bus.d_lock = 1'b0; bus.i_lock = 1'b0;
   endtask

   // Advance to just after the next rising edge to drive the next cycle
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      cyc(); rst = 1'b1; clr_in();
      cyc(); rst = 1'b0;
      @(negedge clk);
   endtask

   typedef struct {
      logic          h, d, i, hwe, dwe;
      logic [2:0]    gnt;     // {I, D, H}
      logic          we;
      logic [AW-1:0] addr;
      logic          hold;
   } vec_t;

   vec_t vt [9];
   int   exp3 [3];

   initial begin
      for (int a = 0; a < (1 << AW); a++) mem[a] = '0;
      mem[9'h000] = 8'h00;
      mem[9'h001] = 8'h08;
      mem[9'h040] = 8'h5A;

      //        h     d     i     hwe   dwe   gnt     we    addr     hold
      vt[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 9'h000, 1'b0};
      vt[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 9'h100, 1'b0};
      vt[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 1'b1, 9'h020, 1'b1};
      vt[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b100, 1'b0, 9'h030, 1'b0};
      vt[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 9'h100, 1'b0};
      vt[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 1'b0, 9'h100, 1'b1};
      vt[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b001, 1'b1, 9'h100, 1'b1};
      vt[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 9'h020, 1'b1};
      vt[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 9'h000, 1'b0};

`ifdef SCPU_ARB_RR_EN
      exp3 = '{4, 2, 4};
`else
      exp3 = '{2, 2, 2};
`endif

      // ---- reset with every requester active ----
      rst = 1'b1;
      clr_in();
      bus.h_req = 1'b1; bus.d_req = 1'b1; bus.i_req = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk);
         @(negedge clk);
         chk("rst_gnt",    gv(), 0);
         chk("rst_rvalid", rv(), 0);
         chk("rst_mem_en", 32'(bus.mem_en), 0);
         chk("rst_hold",   32'(bus.cpu_hold), 0);
      end
      cyc(); rst = 1'b0; clr_in();
      @(negedge clk);
      chk("post_rst_gnt",    gv(), 0);
      chk("post_rst_rvalid", rv(), 0);
      chk("post_rst_mem_en", 32'(bus.mem_en), 0);
      chk("post_rst_hold",   32'(bus.cpu_hold), 0);
      chk("post_rst_addr",   32'(bus.mem_addr), 0);

      // ---- single-cycle arbitration table ----
      for (int k = 0; k < 9; k++) begin
         cyc();
         bus.h_req = vt[k].h;  bus.d_req = vt[k].d;  bus.i_req = vt[k].i;
         bus.h_we  = vt[k].hwe; bus.d_we = vt[k].dwe;
         bus.h_addr = 9'h100; bus.d_addr = 9'h020; bus.i_addr = 9'h030;
         bus.h_wdata = 8'h77; bus.d_wdata = 8'h66;
         @(negedge clk);
         chk($sformatf("vec%0d_gnt", k),    gv(), 32'(vt[k].gnt));
         chk($sformatf("vec%0d_mem_en", k), 32'(bus.mem_en), 32'(|vt[k].gnt));
         chk($sformatf("vec%0d_mem_we", k), 32'(bus.mem_we), 32'(vt[k].we));
         chk($sformatf("vec%0d_addr", k),   32'(bus.mem_addr), 32'(vt[k].addr));
         chk($sformatf("vec%0d_hold", k),   32'(bus.cpu_hold), 32'(vt[k].hold));
      end

      // ---- I fetch pair with D arriving mid-pair ----
      cyc(); clr_in();
      bus.i_req = 1'b1; bus.i_addr = 9'h000; bus.i_lock = 1'b1;
      @(negedge clk);
      chk("ifetch_b0_gnt",  gv(), 4);
      chk("ifetch_b0_addr", 32'(bus.mem_addr), 0);
      cyc();
      bus.i_addr = 9'h001; bus.i_lock = 1'b0;
      bus.d_req = 1'b1; bus.d_addr = 9'h040;
      @(negedge clk);
      chk("ifetch_b1_gnt",    gv(), 4);
      chk("ifetch_b0_rvalid", rv(), 4);
      chk("ifetch_b0_rdata",  32'(bus.rdata), 'h00);
      cyc();
      bus.i_req = 1'b0;
      @(negedge clk);
      chk("ifetch_d_gnt",     gv(), 2);
      chk("ifetch_b1_rvalid", rv(), 4);
      chk("ifetch_b1_rdata",  32'(bus.rdata), 'h08);
      cyc();
      bus.d_req = 1'b0;
      @(negedge clk);
      chk("ifetch_d_rvalid", rv(), 2);
      chk("ifetch_d_rdata",  32'(bus.rdata), 'h5A);

      // ---- three-way contention ----
      do_reset();
      cyc();
      bus.h_req = 1'b1; bus.h_addr = 9'h000;
      bus.d_req = 1'b1; bus.d_addr = 9'h001;
      bus.i_req = 1'b1; bus.i_addr = 9'h040;
      @(negedge clk);
      chk("cont_h_gnt", gv(), 1);
      chk("cont_hold0", 32'(bus.cpu_hold), 0);
      cyc();
      bus.h_req = 1'b0;
      @(negedge clk);
      chk("cont_d_gnt",    gv(), 2);
      chk("cont_hold1",    32'(bus.cpu_hold), 1);
      chk("cont_h_rvalid", 32'(bus.h_rvalid), 1);
      chk("cont_h_rdata",  32'(bus.rdata), 'h00);
      for (int k = 0; k < 3; k++) begin
         cyc();
         @(negedge clk);
         chk($sformatf("cont_di%0d_gnt", k), gv(), 32'(exp3[k]));
         chk($sformatf("cont_di%0d_hold", k), 32'(bus.cpu_hold), 0);
      end
      cyc();
      bus.d_req = 1'b0;
      @(negedge clk);
      chk("cont_i_gnt", gv(), 4);
      cyc();
      bus.i_req = 1'b0;
      @(negedge clk);
      chk("cont_idle_gnt", gv(), 0);

      // ---- D locked write pair, host waits, then reads back ----
      cyc(); clr_in();
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 9'h002;
      bus.d_wdata = 8'h10; bus.d_lock = 1'b1;
      @(negedge clk);
      chk("dwr_b0_gnt",   gv(), 2);
      chk("dwr_b0_we",    32'(bus.mem_we), 1);
      chk("dwr_b0_wdata", 32'(bus.mem_wdata), 'h10);
      cyc();
      bus.d_addr = 9'h003; bus.d_wdata = 8'hAB; bus.d_lock = 1'b0;
      bus.h_req = 1'b1; bus.h_addr = 9'h002;
      @(negedge clk);
      chk("dwr_b1_gnt",    gv(), 2);
      chk("dwr_b1_addr",   32'(bus.mem_addr), 'h003);
      chk("dwr_b1_rvalid", rv(), 0);
      chk("dwr_b1_hold",   32'(bus.cpu_hold), 0);
      cyc();
      bus.d_req = 1'b0; bus.d_we = 1'b0;
      @(negedge clk);
      chk("dwr_h0_gnt",    gv(), 1);
      chk("dwr_h0_rvalid", rv(), 0);
      chk("dwr_h0_hold",   32'(bus.cpu_hold), 0);
      cyc();
      bus.h_addr = 9'h003;
      @(negedge clk);
      chk("dwr_h1_gnt",   gv(), 1);
      chk("dwr_rb0_rv",   rv(), 1);
      chk("dwr_rb0_data", 32'(bus.rdata), 'h10);
      chk("dwr_h1_hold",  32'(bus.cpu_hold), 1);
      cyc();
      bus.h_req = 1'b0;
      @(negedge clk);
      chk("dwr_rb1_rv",   rv(), 1);
      chk("dwr_rb1_data", 32'(bus.rdata), 'hAB);
      chk("dwr_h2_hold",  32'(bus.cpu_hold), 1);
      cyc();
      @(negedge clk);
      chk("dwr_hold_drop", 32'(bus.cpu_hold), 0);

      // ---- lock timeout: D leaves a lock hanging ----
      cyc(); clr_in();
      bus.d_req = 1'b1; bus.d_addr = 9'h000; bus.d_lock = 1'b1;
      @(negedge clk);
      chk("to_d_gnt", gv(), 2);
      cyc();
      bus.d_req = 1'b0; bus.d_lock = 1'b0;
      bus.i_req = 1'b1; bus.i_addr = 9'h001;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) cyc();
         @(negedge clk);
         chk($sformatf("to_block%0d", k), gv(), 0);
      end
      cyc();
      @(negedge clk);
      chk("to_i_gnt", gv(), 4);
      cyc();
      bus.i_req = 1'b0;
      @(negedge clk);
      chk("to_i_rvalid", rv(), 4);
      chk("to_i_rdata",  32'(bus.rdata), 'h08);

      // ---- reset in the cycle after a granted locked I read ----
      cyc(); clr_in();
      bus.i_req = 1'b1; bus.i_addr = 9'h001; bus.i_lock = 1'b1;
      @(negedge clk);
      chk("rmr_i_gnt", gv(), 4);
      cyc();
      rst = 1'b1; clr_in();
      @(negedge clk);
      chk("rmr_squash", rv(), 0);
      cyc();
      rst = 1'b0;
      bus.d_req = 1'b1; bus.d_addr = 9'h000;
      @(negedge clk);
      chk("rmr_d_gnt",  gv(), 2);
      chk("rmr_no_rv",  rv(), 0);
      cyc();
      bus.d_req = 1'b0;
      @(negedge clk);
      chk("rmr_d_rvalid", rv(), 2);
      chk("rmr_d_rdata",  32'(bus.rdata), 'h00);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
